// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, memory-wait freeze and branch flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned FLUSH_LEN   = 1,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        redirect,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        stall1,
  output logic        stall2,
  output logic        branch,
  output logic        mem_err,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [1:0] LP_FLUSH_RELOAD = 2'(FLUSH_LEN - 1);
  localparam logic [1:0] LP_FLUSH_FULL   = 2'(FLUSH_LEN);
  localparam logic [7:0] LP_TIMEOUT      = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_pending;
  logic       w_pending_nxt;
  logic [1:0] r_flush_cnt;
  logic [1:0] w_flush_cnt_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_nxt;
  logic       r_mem_err;
  logic       w_mem_err_nxt;
  logic       w_stall2;
  logic       w_branch;
  logic       w_hazard;

  assign w_hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // Reset forces every control output low; priority is stall2 > branch > stall1.
  assign stall2  = w_stall2 && !reset;
  assign branch  = w_branch && !w_stall2 && !reset;
  assign stall1  = w_hazard && !w_stall2 && !w_branch && !reset;
  assign mem_err = r_mem_err;

  // State register and per-operation bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_flush_cnt <= 2'd0;
      r_wait_cnt  <= 8'd0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_mem_err   <= w_mem_err_nxt;
    end
  end

  // Next-state and raw stall/flush decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_flush_cnt_nxt = r_flush_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_mem_err_nxt   = r_mem_err;
    w_stall2        = 1'b0;
    w_branch        = 1'b0;
    case (r_state)
      IDLE: begin
        if (dmem_req && !dmem_ack) begin
          w_stall2       = 1'b1;
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = 8'd1;
          w_pending_nxt  = redirect;
        end else if (redirect) begin
          w_branch        = 1'b1;
          w_flush_cnt_nxt = LP_FLUSH_RELOAD;
          if (LP_FLUSH_RELOAD != 2'd0) begin
            w_state_nxt = FLUSH;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          w_wait_cnt_nxt = 8'd0;
          w_pending_nxt  = 1'b0;
          // A redirect seen during the wait is replayed in full once memory completes.
          if (r_pending || redirect) begin
            w_state_nxt     = FLUSH;
            w_flush_cnt_nxt = LP_FLUSH_FULL;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_stall2      = 1'b1;
          w_pending_nxt = r_pending || redirect;
          if (r_wait_cnt != LP_TIMEOUT) begin
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            if ((r_wait_cnt + 8'd1) == LP_TIMEOUT) begin
              w_mem_err_nxt = 1'b1;
            end else begin
              w_mem_err_nxt = r_mem_err;
            end
          end else begin
            w_wait_cnt_nxt = r_wait_cnt;
          end
        end
      end
      FLUSH: begin
        w_branch = 1'b1;
        if (redirect) begin
          w_flush_cnt_nxt = LP_FLUSH_RELOAD;
          if (LP_FLUSH_RELOAD != 2'd0) begin
            w_state_nxt = FLUSH;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (r_flush_cnt <= 2'd1) begin
          w_flush_cnt_nxt = 2'd0;
          w_state_nxt     = IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 2'd1;
          w_state_nxt     = FLUSH;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_pending_nxt   = 1'b0;
        w_flush_cnt_nxt = 2'd0;
        w_wait_cnt_nxt  = 8'd0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic        w_flush_accept;

  // A flush is accepted on a direct IDLE redirect or on the ack that starts a replay.
  assign w_flush_accept = !reset &&
                          (((r_state == IDLE) && redirect && !w_stall2) ||
                           ((r_state == MEM_WAIT) && dmem_ack && (r_pending || redirect)));

  // Free-running event counters that wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (stall1 || stall2) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end else begin
        r_perf_stall <= r_perf_stall;
      end
      if (w_flush_accept) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end else begin
        r_perf_flush <= r_perf_flush;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (FLUSH_LEN 1/2/3) share one stimulus stream.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, redirect, dmem_req, dmem_ack;

  logic        s1_a, s2_a, br_a, err_a;
  logic [31:0] ps_a, pf_a;
  logic        s1_b, s2_b, br_b, err_b;
  logic [31:0] ps_b, pf_b;
  logic        s1_c, s2_c, br_c, err_c;
  logic [31:0] ps_c, pf_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_LEN(1), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .redirect(redirect), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .stall1(s1_a), .stall2(s2_a), .branch(br_a),
    .mem_err(err_a), .perf_stall_cnt(ps_a), .perf_flush_cnt(pf_a));

  hazard_ctrl #(.FLUSH_LEN(2), .MEM_TIMEOUT(16)) dut2 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .redirect(redirect), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .stall1(s1_b), .stall2(s2_b), .branch(br_b),
    .mem_err(err_b), .perf_stall_cnt(ps_b), .perf_flush_cnt(pf_b));

  hazard_ctrl #(.FLUSH_LEN(3), .MEM_TIMEOUT(16)) dut3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .redirect(redirect), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .stall1(s1_c), .stall2(s2_c), .branch(br_c),
    .mem_err(err_c), .perf_stall_cnt(ps_c), .perf_flush_cnt(pf_c));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    redirect = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    ex_mem_read = 1'b1; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  initial begin
    clr_in();
    reset = 1'b1;

    // reset: all control outputs held low even with active inputs
    tick();
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); redirect = 1'b1; dmem_req = 1'b1;
    #2;
    check_eq("rst_stall1", 32'(s1_a), 32'd0);
    check_eq("rst_stall2", 32'(s2_a), 32'd0);
    check_eq("rst_branch", 32'(br_a), 32'd0);
    tick(); reset = 1'b0; clr_in(); #2;
    check_eq("rst_mem_err", 32'(err_a), 32'd0);
    check_eq("rst_state", 32'(dut.r_state), 32'd0);
    check_eq("rst_perf_stall", ps_a, 32'd0);
    check_eq("rst_perf_flush", pf_a, 32'd0);

    // load-use
    tick(); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); #2;
    check_eq("lu_rs1", 32'(s1_a), 32'd1);
    tick(); clr_in(); #2;
    check_eq("lu_one_cycle", 32'(s1_a), 32'd0);
    tick(); set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0); #2;
    check_eq("lu_rd_zero", 32'(s1_a), 32'd0);
    tick(); set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1); #2;
    check_eq("lu_rs2", 32'(s1_a), 32'd1);
    tick(); set_lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b0); #2;
    check_eq("lu_no_use", 32'(s1_a), 32'd0);

    // memory wait: ack four cycles after the request
    tick(); clr_in(); dmem_req = 1'b1; set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); #2;
    check_eq("mw_stall2_c0", 32'(s2_a), 32'd1);
    check_eq("mw_stall1_gated", 32'(s1_a), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick(); #2;
      check_eq("mw_stall2_wait", 32'(s2_a), 32'd1);
    end
    tick(); dmem_ack = 1'b1; #2;
    check_eq("mw_stall2_ack", 32'(s2_a), 32'd0);
    check_eq("mw_mem_err", 32'(err_a), 32'd0);
    tick(); clr_in(); #2;
    check_eq("mw_state_idle", 32'(dut.r_state), 32'd0);
    check_eq("mw_stall2_after", 32'(s2_a), 32'd0);
    tick(); dmem_req = 1'b1; dmem_ack = 1'b1; #2;
    check_eq("req_ack_same", 32'(s2_a), 32'd0);
    tick(); clr_in(); #2;
    check_eq("req_ack_idle", 32'(dut.r_state), 32'd0);

    // collision: redirect beats load-use
    tick(); redirect = 1'b1; set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); #2;
    check_eq("col_branch", 32'(br_a), 32'd1);
    check_eq("col_stall1", 32'(s1_a), 32'd0);
    tick(); clr_in(); #2;
    check_eq("col_len1_done", 32'(br_a), 32'd0);
    check_eq("col_len2_hold", 32'(br_b), 32'd1);
    tick(); tick(); tick();

    // redirect during a 3-cycle memory wait, FLUSH_LEN=2
    reset = 1'b1; tick(); reset = 1'b0;
    dmem_req = 1'b1; #2;
    check_eq("rus_stall2_c0", 32'(s2_b), 32'd1);
    tick(); redirect = 1'b1; #2;
    check_eq("rus_stall2_c1", 32'(s2_b), 32'd1);
    check_eq("rus_branch_c1", 32'(br_b), 32'd0);
    tick(); redirect = 1'b0; #2;
    check_eq("rus_branch_c2", 32'(br_b), 32'd0);
    tick(); dmem_ack = 1'b1; #2;
    check_eq("rus_stall2_ack", 32'(s2_b), 32'd0);
    check_eq("rus_branch_ack", 32'(br_b), 32'd0);
    tick(); clr_in(); #2;
    check_eq("rus_branch_r1", 32'(br_b), 32'd1);
    check_eq("rus_len1_r1", 32'(br_a), 32'd1);
    tick(); #2;
    check_eq("rus_branch_r2", 32'(br_b), 32'd1);
    check_eq("rus_len1_r2", 32'(br_a), 32'd0);
    tick(); #2;
    check_eq("rus_branch_end", 32'(br_b), 32'd0);
    check_eq("rus_perf_flush", pf_b, PERF ? 32'd1 : 32'd0);
    check_eq("rus_perf_stall", ps_b, PERF ? 32'd3 : 32'd0);

    // reset in the second branch cycle of a FLUSH_LEN=3 flush
    tick(); redirect = 1'b1; #2;
    check_eq("rmf_branch_c1", 32'(br_c), 32'd1);
    tick(); redirect = 1'b0; reset = 1'b1; #2;
    check_eq("rmf_branch_rst", 32'(br_c), 32'd0);
    tick(); reset = 1'b0; #2;
    check_eq("rmf_branch", 32'(br_c), 32'd0);
    check_eq("rmf_stall1", 32'(s1_c), 32'd0);
    check_eq("rmf_stall2", 32'(s2_c), 32'd0);
    check_eq("rmf_state", 32'(dut3.r_state), 32'd0);
    check_eq("rmf_perf_stall", ps_c, 32'd0);
    check_eq("rmf_perf_flush", pf_c, 32'd0);

    // reset mid-wait discards a pending redirect
    tick(); dmem_req = 1'b1; #2;
    tick(); redirect = 1'b1; #2;
    tick(); redirect = 1'b0; dmem_req = 1'b0; reset = 1'b1; #2;
    tick(); reset = 1'b0; dmem_ack = 1'b1; #2;
    check_eq("pend_drop_stall2", 32'(s2_b), 32'd0);
    check_eq("pend_drop_branch", 32'(br_b), 32'd0);
    tick(); clr_in(); #2;
    check_eq("pend_drop_branch2", 32'(br_b), 32'd0);

    // timeout: ack withheld
    tick(); dmem_req = 1'b1; #2;
    for (int i = 1; i <= 15; i++) begin
      tick(); #2;
      if (i == 15) check_eq("to_err_c15", 32'(err_a), 32'd0);
    end
    tick(); #2;
    check_eq("to_err_c16", 32'(err_a), 32'd1);
    check_eq("to_stall2_c16", 32'(s2_a), 32'd1);
    tick(); dmem_ack = 1'b1; #2;
    check_eq("to_stall2_ack", 32'(s2_a), 32'd0);
    check_eq("to_err_ack", 32'(err_a), 32'd1);
    tick(); clr_in(); #2;
    check_eq("to_err_sticky", 32'(err_a), 32'd1);
    check_eq("to_state", 32'(dut.r_state), 32'd0);
    tick(); reset = 1'b1; tick(); reset = 1'b0; #2;
    check_eq("to_err_cleared", 32'(err_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
